// File: rtl/ub_pkg.sv
// Shared widths, coefficient/offset matrix types and default access patterns
// for the affine stencil buffer.
package ub_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CTRL_W     = 16;
    localparam int COORD_W    = 32;
    localparam int NDIM       = 3;
    localparam int MAX_CTRL   = 8;
    localparam int MAX_TAP    = 8;

    // Matrices are stored as fixed-size packed arrays so that parameter
    // types do not depend on NCTRL/NTAP; only the leading entries are used.
    typedef logic [COORD_W-1:0]         coef_t;
    typedef coef_t [MAX_CTRL-1:0]       coef_row_t;
    typedef coef_row_t [NDIM-1:0]       coef_mat_t;
    typedef coef_t [NDIM-1:0]           off_vec_t;
    typedef off_vec_t [MAX_TAP-1:0]     off_mat_t;

    // Loop index order: ctrl[0]=x, ctrl[1]=y, ctrl[2]=channel.
    // Box dims: dim0=channel (fastest), dim1=x, dim2=y.
    localparam coef_mat_t WR_COEF_DEF = '{
        0: '{2: 32'd1, default: '0},
        1: '{0: 32'd1, default: '0},
        2: '{1: 32'd1, default: '0}
    };

    localparam coef_mat_t RD_COEF_DEF = '{
        0: '{2: 32'd2, default: '0},
        1: '{0: 32'd2, default: '0},
        2: '{1: 32'd2, default: '0}
    };

    // 2x2 window: tap0 (x,y), tap1 (x+1,y), tap2 (x+1,y+1), tap3 (x,y+1).
    localparam off_mat_t RD_OFF_DEF = '{
        1:       '{1: 32'd1, default: '0},
        2:       '{1: 32'd1, 2: 32'd1, default: '0},
        3:       '{2: 32'd1, default: '0},
        default: '0
    };

    function automatic logic in_range(input logic signed [COORD_W-1:0] v, input int ext);
        return (v >= 0) && (v < ext);
    endfunction

endpackage

// File: rtl/ub_affine_addr.sv
// Combinational affine map: loop indices -> box coordinates -> linear
// address, plus an in-box flag. Loop indices are signed 16-bit values.
module ub_affine_addr
    import ub_pkg::*;
#(
    parameter int        NCTRL  = 4,
    parameter int        EXT0   = 4,
    parameter int        EXT1   = 64,
    parameter int        EXT2   = 64,
    parameter int        ADDR_W = 14,
    parameter coef_mat_t COEF   = '0,
    parameter off_vec_t  OFF    = '0
) (
    input  logic [NCTRL-1:0][CTRL_W-1:0] ctrl_vars,
    output logic [ADDR_W-1:0]            addr,
    output logic                         inbox
);

    logic signed [COORD_W-1:0] coord [NDIM];

    // Per-dimension dot product of the coefficient row with the indices.
    always_comb begin
        logic signed [COORD_W-1:0] acc;
        // NOTE: every variable gets a value before any branch/loop so no latch is inferred
        acc = '0;
        for (int d = 0; d < NDIM; d++) begin
            acc = $signed(OFF[d]);
            for (int k = 0; k < NCTRL; k++) begin
                acc = acc + $signed(COEF[d][k]) * COORD_W'($signed(ctrl_vars[k]));
            end
            coord[d] = acc;
        end
    end

    assign inbox = in_range(coord[0], EXT0) && in_range(coord[1], EXT1) &&
                   in_range(coord[2], EXT2);

    // Meaningful only when inbox is set; callers gate on it.
    assign addr = ADDR_W'(coord[0] + coord[1] * EXT0 + coord[2] * (EXT0 * EXT1));

endmodule

// File: rtl/affine_stencil_ub.sv
// Affine-addressed unified buffer: one write port, NTAP read taps sharing a
// read strobe, write-first forwarding, READ_LAT-deep read pipeline and a
// sticky out-of-box error flag.
module affine_stencil_ub
    import ub_pkg::*;
#(
    parameter int        DATA_W   = DATA_W_DEF,
    parameter int        NCTRL    = 4,
    parameter int        NTAP     = 4,
    parameter int        EXT0     = 4,
    parameter int        EXT1     = 64,
    parameter int        EXT2     = 64,
    parameter int        READ_LAT = 1,
    parameter coef_mat_t WR_COEF  = WR_COEF_DEF,
    parameter coef_mat_t RD_COEF  = RD_COEF_DEF,
    parameter off_mat_t  RD_OFF   = RD_OFF_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         wr_wen,
    input  logic [NCTRL-1:0][CTRL_W-1:0] wr_ctrl_vars,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rd_ren,
    input  logic [NCTRL-1:0][CTRL_W-1:0] rd_ctrl_vars,
    output logic [NTAP-1:0][DATA_W-1:0]  rd_data,
    output logic                         rd_valid,
    output logic                         oob_err
);

    localparam int CAPACITY = EXT0 * EXT1 * EXT2;
    localparam int ADDR_W   = $clog2(CAPACITY);

    typedef logic [NTAP-1:0][DATA_W-1:0] taps_t;

    logic [DATA_W-1:0] mem [CAPACITY];

    logic [ADDR_W-1:0] wr_addr;
    logic              wr_inbox;
    logic              wr_commit;
    logic [ADDR_W-1:0] tap_addr [NTAP];
    logic [NTAP-1:0]   tap_inbox;
    taps_t             tap_word;
    logic              oob_now;

    logic [READ_LAT-1:0] pipe_valid;
    taps_t               pipe_data [READ_LAT];

    ub_affine_addr #(
        .NCTRL(NCTRL), .EXT0(EXT0), .EXT1(EXT1), .EXT2(EXT2), .ADDR_W(ADDR_W),
        .COEF(WR_COEF), .OFF('0)
    ) u_wr_addr (
        .ctrl_vars (wr_ctrl_vars),
        .addr      (wr_addr),
        .inbox     (wr_inbox)
    );

    for (genvar t = 0; t < NTAP; t++) begin : g_tap
        ub_affine_addr #(
            .NCTRL(NCTRL), .EXT0(EXT0), .EXT1(EXT1), .EXT2(EXT2), .ADDR_W(ADDR_W),
            .COEF(RD_COEF), .OFF(RD_OFF[t])
        ) u_tap_addr (
            .ctrl_vars (rd_ctrl_vars),
            .addr      (tap_addr[t]),
            .inbox     (tap_inbox[t])
        );
    end

    assign wr_commit = wr_wen & wr_inbox;
    assign oob_now   = (wr_wen & ~wr_inbox) | (rd_ren & ~(&tap_inbox));

    // Tap words: zero outside the box, same-cycle write forwarded, else RAM.
    always_comb begin
        tap_word = '0;
        for (int t = 0; t < NTAP; t++) begin
            if (tap_inbox[t]) begin
                if (wr_commit && (tap_addr[t] == wr_addr)) tap_word[t] = wr_data;
                else                                       tap_word[t] = mem[tap_addr[t]];
            end
        end
    end

    // Storage write port; out-of-box writes never reach the array.
    // NOTE: the storage array has no reset; contents survive reset and flush
    always_ff @(posedge clk) begin
        if (wr_commit) mem[wr_addr] <= wr_data;
    end

    // Read latency pipeline and sticky error flag; data stages only load
    // when their valid moves in, so the output holds between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= '0;
            for (int s = 0; s < READ_LAT; s++) pipe_data[s] <= '0;
            oob_err <= 1'b0;
        end else if (flush) begin
            pipe_valid <= '0;
            oob_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking so each stage samples its predecessor's pre-edge value
            pipe_valid[0] <= rd_ren;
            if (rd_ren) pipe_data[0] <= tap_word;
            for (int s = 1; s < READ_LAT; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                if (pipe_valid[s-1]) pipe_data[s] <= pipe_data[s-1];
            end
            if (oob_now) oob_err <= 1'b1;
        end
    end

    assign rd_data  = pipe_data[READ_LAT-1];
    assign rd_valid = pipe_valid[READ_LAT-1];

endmodule

// File: tb/tb_affine_stencil_ub.sv
// Bench for affine_stencil_ub: two instances share all stimulus
// (A: defaults, B: READ_LAT=2 with EXT1=63) and are compared every cycle
// against a behavioural model of the box, plus directed scenario checks.
module tb_affine_stencil_ub;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             wr_wen;
    logic [3:0][15:0] wr_ctrl;
    logic [15:0]      wr_data;
    logic             rd_ren;
    logic [3:0][15:0] rd_ctrl;
    logic [3:0][15:0] rd_data_a, rd_data_b;
    logic             rd_valid_a, rd_valid_b;
    logic             oob_err_a, oob_err_b;

    int n_vec = 0;
    int n_err = 0;

    affine_stencil_ub u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_wen(wr_wen), .wr_ctrl_vars(wr_ctrl), .wr_data(wr_data),
        .rd_ren(rd_ren), .rd_ctrl_vars(rd_ctrl),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .oob_err(oob_err_a)
    );

    affine_stencil_ub #(.READ_LAT(2), .EXT1(63)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_wen(wr_wen), .wr_ctrl_vars(wr_ctrl), .wr_data(wr_data),
        .rd_ren(rd_ren), .rd_ctrl_vars(rd_ctrl),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .oob_err(oob_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [2][16384];
    bit          sched_v [2][8];
    logic [63:0] sched_d [2][8];
    bit          m_valid [2];
    logic [63:0] m_data  [2];
    bit          m_oob   [2];
    int          cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Box: dim0=channel (4), dim1=x (ext1), dim2=y (64). Reads use stride 2
    // on every index and the 2x2 window offsets on x/y.
    function automatic bit map_addr(input int ext1, input logic [3:0][15:0] c,
                                    input bit is_rd, input int tap, output int addr);
        int x, y, ch, d0, d1, d2;
        x  = int'($signed(c[0]));
        y  = int'($signed(c[1]));
        ch = int'($signed(c[2]));
        if (is_rd) begin
            d0 = 2 * ch;
            d1 = 2 * x + ((tap == 1 || tap == 2) ? 1 : 0);
            d2 = 2 * y + ((tap >= 2) ? 1 : 0);
        end else begin
            d0 = ch; d1 = x; d2 = y;
        end
        addr = d0 + 4 * d1 + 4 * ext1 * d2;
        return (d0 >= 0) && (d0 < 4) && (d1 >= 0) && (d1 < ext1) && (d2 >= 0) && (d2 < 64);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = '0;
            m_oob[i]   = 1'b0;
            for (int s = 0; s < 8; s++) sched_v[i][s] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int ext1, lat, waddr, a, slot;
        bit wok, any_oob;
        logic [63:0] taps;
        if (!rst_n) begin
            model_reset();
            return;
        end
        cyc++;
        for (int i = 0; i < 2; i++) begin
            ext1 = (i == 0) ? 64 : 63;
            lat  = (i == 0) ? 1 : 2;
            wok  = map_addr(ext1, wr_ctrl, 1'b0, 0, waddr);
            taps = '0;
            any_oob = 1'b0;
            for (int t = 0; t < 4; t++) begin
                if (!map_addr(ext1, rd_ctrl, 1'b1, t, a)) any_oob = 1'b1;
                else if (wr_wen && wok && a == waddr) taps[16*t +: 16] = wr_data;
                else taps[16*t +: 16] = ref_mem[i][a];
            end
            if (flush) begin
                for (int s = 0; s < 8; s++) sched_v[i][s] = 1'b0;
                m_oob[i] = 1'b0;
            end else begin
                if (rd_ren) begin
                    slot = (cyc + lat - 1) % 8;
                    sched_v[i][slot] = 1'b1;
                    sched_d[i][slot] = taps;
                end
                if ((wr_wen && !wok) || (rd_ren && any_oob)) m_oob[i] = 1'b1;
            end
            if (wr_wen && wok) ref_mem[i][waddr] = wr_data;
            slot = cyc % 8;
            m_valid[i] = sched_v[i][slot];
            if (sched_v[i][slot]) begin
                m_data[i] = sched_d[i][slot];
                sched_v[i][slot] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check("a.rd_valid", rd_valid_a, m_valid[0]);
        check("a.oob_err",  oob_err_a,  m_oob[0]);
        check("a.rd_data",  rd_data_a,  m_data[0]);
        check("b.rd_valid", rd_valid_b, m_valid[1]);
        check("b.oob_err",  oob_err_b,  m_oob[1]);
        check("b.rd_data",  rd_data_b,  m_data[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_rd(input bit en, input int x, input int y);
        rd_ren     = en;
        rd_ctrl[0] = 16'(x);
        rd_ctrl[1] = 16'(y);
        rd_ctrl[2] = '0;
        rd_ctrl[3] = 16'($urandom);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; flush = 1'b0; wr_wen = 1'b0; rd_ren = 1'b0;
        wr_ctrl = '0; rd_ctrl = '0; wr_data = '0;
        model_reset();

        repeat (2) tick();
        check("reset.rd_data_a", rd_data_a, 64'd0);
        check("reset.rd_valid_b", rd_valid_b, 1'b0);
        rst_n = 1'b1;

        // Fill channel-0 plane with x + 64*y (B drops x=63 as out-of-box).
        for (int y = 0; y < 64; y++) begin
            for (int x = 0; x < 64; x++) begin
                wr_wen  = 1'b1;
                wr_ctrl = '0;
                wr_ctrl[0] = 16'(x);
                wr_ctrl[1] = 16'(y);
                wr_data = 16'(x + 64 * y);
                tick();
            end
        end
        wr_wen = 1'b0;
        check("fill.oob_a", oob_err_a, 1'b0);
        check("fill.oob_b", oob_err_b, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush.oob_b", oob_err_b, 1'b0);

        // 2x2 window read at x=5, y=3.
        set_rd(1'b1, 5, 3);
        tick();
        set_rd(1'b0, 0, 0);
        check("win.valid_a", rd_valid_a, 1'b1);
        check("win.data_a", rd_data_a, {16'd458, 16'd459, 16'd395, 16'd394});
        check("win.valid_b_early", rd_valid_b, 1'b0);
        tick();
        check("win.valid_a_once", rd_valid_a, 1'b0);
        check("win.data_a_hold", rd_data_a, {16'd458, 16'd459, 16'd395, 16'd394});
        check("win.data_b", rd_data_b, {16'd458, 16'd459, 16'd395, 16'd394});
        tick();

        // Back-to-back reads at x=0,1,2 through the two-cycle instance.
        for (int i = 0; i < 5; i++) begin
            if (i < 3) set_rd(1'b1, i, 0);
            else       set_rd(1'b0, 0, 0);
            tick();
            check("b2b.valid_b", rd_valid_b, (i >= 1 && i <= 3));
            if (i >= 1 && i <= 3) check("b2b.tap0_b", rd_data_b[0], 16'(2 * (i - 1)));
        end

        // Same-cycle write of 0xBEEF to (x=2,y=0) forwarded to tap0 of read x=1.
        wr_wen = 1'b1;
        wr_ctrl = '0;
        wr_ctrl[0] = 16'd2;
        wr_data = 16'hBEEF;
        set_rd(1'b1, 1, 0);
        tick();
        wr_wen = 1'b0;
        set_rd(1'b0, 0, 0);
        check("fwd.tap0_a", rd_data_a[0], 16'hBEEF);
        tick();
        check("fwd.tap0_b", rd_data_b[0], 16'hBEEF);

        // Window straddling x edge of B (EXT1=63): taps 1,2 land on x=63.
        set_rd(1'b1, 31, 0);
        tick();
        set_rd(1'b0, 0, 0);
        check("edge.oob_b", oob_err_b, 1'b1);
        check("edge.oob_a", oob_err_a, 1'b0);
        tick();
        check("edge.tap1_b", rd_data_b[1], 16'd0);
        check("edge.tap2_b", rd_data_b[2], 16'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("edge.flush_oob_b", oob_err_b, 1'b0);
        set_rd(1'b1, 31, 0);
        tick();
        set_rd(1'b0, 0, 0);
        tick();
        check("edge.ram_kept_b", rd_data_b[0], 16'd62);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Random traffic: writes anywhere (some out of box), reads on channel 0.
        for (int n = 0; n < 1500; n++) begin
            wr_wen = ($urandom_range(0, 1) == 1);
            if (wr_wen) begin
                wr_ctrl[0] = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 70));
                wr_ctrl[1] = 16'($urandom_range(0, 66));
                wr_ctrl[2] = 16'($urandom_range(0, 4));
                wr_ctrl[3] = 16'($urandom);
            end else begin
                wr_ctrl = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
            end
            wr_data = 16'($urandom);
            if ($urandom_range(0, 9) < 6) begin
                set_rd(1'b1, int'($urandom_range(0, 34)), int'($urandom_range(0, 33)));
                if ($urandom_range(0, 15) == 0) rd_ctrl[0] = 16'hFFFF;
                if ($urandom_range(0, 15) == 0) rd_ctrl[1] = 16'hFFFF;
            end else begin
                rd_ren  = 1'b0;
                rd_ctrl = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
            end
            flush = ($urandom_range(0, 31) == 0);
            tick();
        end
        wr_wen = 1'b0; flush = 1'b0;
        set_rd(1'b0, 0, 0);
        tick();

        // Reset asserted one cycle after a read: B's in-flight read is lost.
        set_rd(1'b1, 4, 4);
        tick();
        set_rd(1'b0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("rst.valid_b", rd_valid_b, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst.no_pulse_b", rd_valid_b, 1'b0);
            check("rst.data_b", rd_data_b, 64'd0);
            check("rst.data_a", rd_data_a, 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
